mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch and data access.
// Ack/err/rdata are registered; the BUSY_x state drives m_* only from captured request fields.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        last_d;
  logic [7:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        i_elig, d_elig, pick_d, timeout_hit;

  // A port whose ack is out this cycle still shows its old request; ignore it.
  assign i_elig      = i_req & ~i_ack;
  assign d_elig      = d_req & ~d_ack;
  assign pick_d      = d_elig & (~i_elig | ~last_d);
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_be    = be_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d)      state_nxt = BUSY_D;
        else if (i_elig) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (m_ack || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_req = 1'b0;
    m_we  = 1'b0;
    grant = 2'b00;
    case (state)
      BUSY_I: begin
        m_req = 1'b1;
        grant = 2'b01;
      end
      BUSY_D: begin
        m_req = 1'b1;
        m_we  = we_q;
        grant = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d  <= 1'b0;
      cnt     <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (pick_d) begin
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            be_q    <= d_be;
            last_d  <= 1'b1;
          end else if (i_elig) begin
            addr_q  <= i_addr;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            be_q    <= 4'hF;
            last_d  <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_ack) begin
            if (state == BUSY_I) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              if (!we_q) d_rdata <= m_rdata;
              d_ack <= 1'b1;
            end
          end else if (timeout_hit) begin
            if (state == BUSY_I) begin
              i_ack <= 1'b1;
              i_err <= 1'b1;
            end else begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small RAM responder of programmable wait states.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, i_err, d_ack, d_err, m_req, m_we, m_ack;
  logic [3:0]  m_be;
  logic [1:0]  grant;

  logic        ram_en, force_ack;
  logic [7:0]  ram_wait, mcnt;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack), .grant(grant)
  );

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0050_0093;
      32'h104: return 32'h1111_1111;
      32'h300: return 32'h3333_3333;
      32'h500: return 32'h5555_5555;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  // RAM acks on the (ram_wait+1)-th cycle of a held request; wait 0 acks in the same cycle.
  assign m_ack   = force_ack | (ram_en & m_req & (mcnt == ram_wait));
  assign m_rdata = rdata_for(m_addr);

  always_ff @(posedge clk) begin
    if (m_req && !m_ack) mcnt <= mcnt + 8'd1;
    else                 mcnt <= 8'd0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    reset = 1'b0;
    drive_edge();
    drive_edge();
    reset = 1'b1;
  endtask

  logic [1:0] exp_grant [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  logic       exp_dack  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       exp_iack  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int  n;
    bit  started, done, stray;
    mcnt = 8'd0;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    ram_en = 1'b1; ram_wait = 8'd0; force_ack = 1'b0;

    // Reset state
    drive_edge();
    drive_edge();
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_errs", {30'd0, i_err, d_err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    drive_edge();
    reset = 1'b1;

    // Zero-wait fetch: m_req at N+1, i_ack at N+2
    drive_edge();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("f_n_m_req", 32'(m_req), 32'd0);
    @(negedge clk);
    chk("f_n1_m_req", 32'(m_req), 32'd1);
    chk("f_n1_grant", 32'(grant), 32'd1);
    chk("f_n1_m_addr", m_addr, 32'h100);
    chk("f_n1_m_be", 32'(m_be), 32'hF);
    chk("f_n1_m_we", 32'(m_we), 32'd0);
    @(negedge clk);
    chk("f_n2_i_ack", 32'(i_ack), 32'd1);
    chk("f_n2_i_err", 32'(i_err), 32'd0);
    chk("f_n2_i_rdata", i_rdata, 32'h0050_0093);
    chk("f_n2_m_req", 32'(m_req), 32'd0);
    drive_edge();
    i_req = 1'b0;
    @(negedge clk);
    chk("f_n3_no_reissue", 32'(m_req), 32'd0);
    chk("f_n3_i_ack", 32'(i_ack), 32'd0);

    // Contention after reset: data first (store), then instr
    do_reset();
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("c_grant_d", 32'(grant), 32'd2);
    chk("c_m_we", 32'(m_we), 32'd1);
    chk("c_m_addr", m_addr, 32'h200);
    chk("c_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("c_m_be", 32'(m_be), 32'hF);
    @(negedge clk);
    chk("c_d_ack", 32'(d_ack), 32'd1);
    chk("c_d_err", 32'(d_err), 32'd0);
    chk("c_i_ack_quiet", 32'(i_ack), 32'd0);
    chk("c_d_rdata_store", d_rdata, 32'd0);
    drive_edge();
    d_req = 1'b0;
    @(negedge clk);
    chk("c_grant_i", 32'(grant), 32'd1);
    chk("c_i_m_addr", m_addr, 32'h104);
    chk("c_i_m_we", 32'(m_we), 32'd0);
    chk("c_i_m_wdata", m_wdata, 32'd0);
    @(negedge clk);
    chk("c_i_ack", 32'(i_ack), 32'd1);
    chk("c_i_rdata", i_rdata, 32'h1111_1111);
    chk("c_d_rdata_hold", d_rdata, 32'd0);
    drive_edge();
    i_req = 1'b0;

    // Continuous requests: D,I,D,I with a single ack each
    drive_edge();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(negedge clk);
    chk("rr_start_grant", 32'(grant), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_grant[k]));
      chk($sformatf("rr_acks_%0d", k), {30'd0, i_ack, d_ack}, {30'd0, exp_iack[k], exp_dack[k]});
      if (k == 6) begin
        drive_edge();
        d_req = 1'b0;
      end
    end
    chk("rr_d_rdata", d_rdata, 32'h3333_3333);
    drive_edge();
    i_req = 1'b0;
    @(negedge clk);
    chk("rr_idle_after", 32'(m_req), 32'd0);

    // Spurious m_ack in IDLE is ignored
    drive_edge();
    force_ack = 1'b1;
    @(negedge clk);
    chk("spur_m_req", 32'(m_req), 32'd0);
    drive_edge();
    force_ack = 1'b0;
    @(negedge clk);
    chk("spur_acks", {30'd0, i_ack, d_ack}, 32'd0);

    // Timeout on a load: 16 BUSY cycles then d_ack with d_err
    ram_en = 1'b0;
    drive_edge();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    n = 0; started = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (m_req) begin
        n++;
        started = 1;
      end else if (started) begin
        done = 1;
      end
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_busy_cycles", 32'(n), 32'd16);
    chk("to_d_ack", 32'(d_ack), 32'd1);
    chk("to_d_err", 32'(d_err), 32'd1);
    chk("to_grant", 32'(grant), 32'd0);
    chk("to_d_rdata_hold", d_rdata, 32'h3333_3333);
    drive_edge();
    d_req = 1'b0;
    ram_en = 1'b1;
    @(negedge clk);
    chk("to_after_ack", 32'(d_ack), 32'd0);

    // m_ack on the timeout cycle completes normally
    ram_wait = 8'd15;
    drive_edge();
    d_req = 1'b1; d_addr = 32'h500;
    n = 0; started = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (m_req) begin
        n++;
        started = 1;
      end else if (started) begin
        done = 1;
      end
    end
    chk("race_done", 32'(done), 32'd1);
    chk("race_busy_cycles", 32'(n), 32'd16);
    chk("race_d_ack", 32'(d_ack), 32'd1);
    chk("race_d_err", 32'(d_err), 32'd0);
    chk("race_d_rdata", d_rdata, 32'h5555_5555);
    drive_edge();
    d_req = 1'b0;

    // Reset on second BUSY_I cycle with a 3-wait RAM
    ram_wait = 8'd3;
    drive_edge();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("mr_busy1", 32'(m_req), 32'd1);
    drive_edge();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy2", 32'(m_req), 32'd1);
    drive_edge();
    reset = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    chk("mr_m_req", 32'(m_req), 32'd0);
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_i_ack", 32'(i_ack), 32'd0);
    chk("mr_i_rdata", i_rdata, 32'd0);
    chk("mr_d_rdata", d_rdata, 32'd0);
    chk("mr_m_addr", m_addr, 32'd0);
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_ack || d_ack || m_req) stray = 1;
    end
    chk("mr_no_late_ack", 32'(stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
